// File: rtl/riscv_isa_pkg.sv
// RV32 R-type field constants, the field tuple layout and the legality rule
// for the ALU ops the encoder accepts.
package riscv_isa_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] F7_BASE    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    // Field order matches the instruction word from bit 31 down to bit 0.
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rtype_fields_t;

    // Base encodings are always legal; the alternate funct7 only exists for sub and sra.
    function automatic logic is_legal_rtype(
        input logic [6:0] opcode,
        input logic [2:0] funct3,
        input logic [6:0] funct7
    );
        logic alt_ok;
        alt_ok = (funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA));
        return (opcode == OPC_RTYPE) && ((funct7 == F7_BASE) || alt_ok);
    endfunction

endpackage

// File: rtl/rtype_instr_encoder_sync_fifo.sv
// Small synchronous FIFO with a registered head word. The head register holds
// its last value once the FIFO drains and returns to zero on reset or flush.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_nx_c;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n_c;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_n_c;
    logic             full_q;
    logic             empty_q;
    logic             push_ok_c;
    logic             pop_ok_c;

    // Qualified push/pop, next occupancy and the word that becomes head next cycle.
    always_comb begin
        push_ok_c   = push && !full_q;
        pop_ok_c    = pop && !empty_q;
        rd_ptr_nx_c = rd_ptr_q + PTR_W'(1);
        cnt_n_c     = cnt_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
        head_n_c    = head_q;
        if (pop_ok_c && (cnt_q > CNT_W'(1))) begin
            head_n_c = mem[rd_ptr_nx_c];
        end else if (push_ok_c && (empty_q || pop_ok_c)) begin
            head_n_c = wdata;
        end
    end

    // Pointers, occupancy flags and head register; flush behaves like reset.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr_q <= rd_ptr_nx_c;
            end
            cnt_q   <= cnt_n_c;
            full_q  <= (cnt_n_c == CNT_W'(DEPTH));
            empty_q <= (cnt_n_c == '0);
            head_q  <= head_n_c;
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = head_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign count = cnt_q;

endmodule

// File: rtl/rtype_instr_encoder.sv
// Packs legal R-type field tuples into RV32 words tagged with a running
// word address and streams them through a small FIFO. Illegal tuples are
// consumed, dropped and counted.
module rtype_instr_encoder
    import riscv_isa_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 8,
    parameter int unsigned        DEPTH     = 4,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         opcode,
    input  logic [4:0]         rd,
    input  logic [2:0]         funct3,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [6:0]         funct7,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               err_illegal,
    output logic [7:0]         illegal_cnt
);
    localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [7:0]  CNT_MAX = 8'hFF;

    rtype_fields_t      fields_c;
    logic               legal_c;
    logic               accept_c;
    logic               push_c;
    logic               illegal_c;
    logic [ENTRY_W-1:0] fifo_wdata_c;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    logic [ADDR_W-1:0]  addr_q;
    logic               rdy_q;
    logic               err_q;
    logic [7:0]         cnt_q;

    // Handshake, legality and the packed entry (instruction word above its address).
    always_comb begin
        fields_c        = '0;
        fields_c.funct7 = funct7;
        fields_c.rs2    = rs2;
        fields_c.rs1    = rs1;
        fields_c.funct3 = funct3;
        fields_c.rd     = rd;
        fields_c.opcode = opcode;

        in_ready     = rdy_q && !fifo_full;
        legal_c      = is_legal_rtype(opcode, funct3, funct7);
        accept_c     = in_valid && in_ready;
        push_c       = accept_c && legal_c && !clear;
        illegal_c    = accept_c && !legal_c && !clear;
        fifo_wdata_c = {INSTR_W'(fields_c), addr_q};
    end

    // Address counter, illegal-tuple pulse and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= BASE_ADDR;
            rdy_q  <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            rdy_q <= 1'b1;
            err_q <= illegal_c;
            if (clear) begin
                addr_q <= BASE_ADDR;
                cnt_q  <= '0;
            end else begin
                if (push_c) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
                if (illegal_c && (cnt_q != CNT_MAX)) begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clear),
        .push  (push_c),
        .wdata (fifo_wdata_c),
        .pop   (out_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid   = !fifo_empty;
    assign out_instr   = fifo_rdata[ENTRY_W-1 -: INSTR_W];
    assign out_addr    = fifo_rdata[ADDR_W-1:0];
    assign err_illegal = err_q;
    assign illegal_cnt = cnt_q;

    // Buffer occupancy never exceeds its depth.
    count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
                                     fifo_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_rtype_instr_encoder.sv
// Scoreboard bench for rtype_instr_encoder: the driver feeds a field-level
// reference model that queues expected words; a negedge monitor compares the
// DUT outputs against the queue head every cycle.
module tb_rtype_instr_encoder;
    localparam int unsigned       ADDR_W = 8;
    localparam int unsigned       DEPTH  = 4;
    localparam logic [ADDR_W-1:0] BASE   = '0;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [6:0]        funct7;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_illegal;
    logic [7:0]        illegal_cnt;

    rtype_instr_encoder #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .rd          (rd),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct7      (funct7),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_addr    (out_addr),
        .err_illegal (err_illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] instr; logic [ADDR_W-1:0] addr; } exp_t;
    typedef struct { logic [31:0] instr; logic [ADDR_W-1:0] addr; int cyc; } seen_t;

    exp_t              exp_q[$];
    seen_t             seen_q[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc = 0;
    logic [ADDR_W-1:0] addr_m = '0;
    int                cnt_m = 0;
    logic              exp_err = 1'b0;
    logic              rdy_m = 1'b0;
    logic              mon_en = 1'b0;
    logic [31:0]       last_instr = '0;
    logic [ADDR_W-1:0] last_addr = '0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endfunction

    // Supported op set: any base-funct7 R-type, plus sub/sra with funct7=0x20.
    function automatic bit ref_legal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        if (op != 7'b0110011) return 1'b0;
        if (f7 == 7'h00) return 1'b1;
        return (f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5));
    endfunction

    function automatic logic [31:0] ref_pack(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                                             input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7);
        return {f7, s2, s1, f3, d, op};
    endfunction

    function automatic void model_flush();
        exp_q.delete();
        addr_m     = BASE;
        cnt_m      = 0;
        last_instr = '0;
        last_addr  = '0;
    endfunction

    // Monitor: every cycle compare flags and head against the model, pop on transfer.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            check("in_ready", 64'(in_ready), 64'(rdy_m && (exp_q.size() < int'(DEPTH))));
            check("err_illegal", 64'(err_illegal), 64'(exp_err));
            check("illegal_cnt", 64'(illegal_cnt), 64'(cnt_m));
            if (exp_q.size() != 0) begin
                check("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
                check("out_addr", 64'(out_addr), 64'(exp_q[0].addr));
                if (out_ready && rst_n && !clear) begin
                    last_instr = exp_q[0].instr;
                    last_addr  = exp_q[0].addr;
                    void'(exp_q.pop_front());
                end
            end else begin
                check("idle_instr", 64'(out_instr), 64'(last_instr));
                check("idle_addr", 64'(out_addr), 64'(last_addr));
            end
            if (out_valid && out_ready && rst_n && !clear)
                seen_q.push_back('{out_instr, out_addr, cyc});
        end
    end

    // One clock of stimulus; the model is updated #1 after the edge.
    task automatic step(input logic v, input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                        input logic clr, input logic rstn, output logic fired);
        in_valid = v;
        opcode   = op;
        rd       = d;
        funct3   = f3;
        rs1      = s1;
        rs2      = s2;
        funct7   = f7;
        clear    = clr;
        rst_n    = rstn;
        @(negedge clk);
        fired = in_valid && in_ready && rst_n;
        @(posedge clk);
        #1;
        exp_err = 1'b0;
        if (!rstn) begin
            model_flush();
            rdy_m  = 1'b0;
            mon_en = 1'b1;
        end else begin
            rdy_m = 1'b1;
            if (clr) begin
                model_flush();
            end else if (fired) begin
                if (ref_legal(op, f3, f7)) begin
                    exp_q.push_back('{ref_pack(op, d, f3, s1, s2, f7), addr_m});
                    addr_m = ADDR_W'(addr_m + 1'b1);
                end else begin
                    cnt_m   = (cnt_m == 255) ? 255 : cnt_m + 1;
                    exp_err = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        logic f;
        for (int i = 0; i < n; i++)
            step(1'b0, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 7'($urandom),
                 1'b0, 1'b1, f);
    endtask

    task automatic do_clear();
        logic f;
        step(1'b0, 7'h33, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 1'b1, 1'b1, f);
    endtask

    task automatic push_tuple(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7);
        logic f;
        f = 1'b0;
        for (int i = 0; i < 40 && !f; i++)
            step(1'b1, op, d, f3, s1, s2, f7, 1'b0, 1'b1, f);
        in_valid = 1'b0;
        if (!f) check("push_timeout", 64'(f), 64'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        f;
        logic [31:0] hold_i;
        out_ready = 1'b1;

        // Reset
        for (int i = 0; i < 3; i++)
            step(1'b0, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 1'b0, 1'b0, f);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_instr", 64'(out_instr), 64'(0));
        check("rst_out_addr", 64'(out_addr), 64'(0));
        check("rst_err", 64'(err_illegal), 64'(0));
        check("rst_cnt", 64'(illegal_cnt), 64'(0));
        idle(1);

        // add x3,x1,x2
        seen_q.delete();
        push_tuple(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00);
        check("add_instr", 64'(out_instr), 64'h002081B3);
        check("add_addr", 64'(out_addr), 64'h0);
        idle(2);

        // sub x5,x6,x7 then sra x1,x2,x3 back to back
        do_clear();
        seen_q.delete();
        push_tuple(7'h33, 5'd5, 3'd0, 5'd6, 5'd7, 7'h20);
        push_tuple(7'h33, 5'd1, 3'd5, 5'd2, 5'd3, 7'h20);
        idle(3);
        check("b2b_count", 64'(seen_q.size()), 64'(2));
        if (seen_q.size() >= 2) begin
            check("sub_instr", 64'(seen_q[0].instr), 64'h407302B3);
            check("sub_addr", 64'(seen_q[0].addr), 64'h0);
            check("sra_instr", 64'(seen_q[1].instr), 64'h403150B3);
            check("sra_addr", 64'(seen_q[1].addr), 64'h1);
            check("b2b_no_bubble", 64'(seen_q[1].cyc - seen_q[0].cyc), 64'(1));
        end

        // Illegal tuple between two adds
        do_clear();
        seen_q.delete();
        push_tuple(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00);
        push_tuple(7'h33, 5'd3, 3'd7, 5'd1, 5'd2, 7'h20);
        check("ill_err_pulse", 64'(err_illegal), 64'(1));
        check("ill_cnt", 64'(illegal_cnt), 64'(1));
        push_tuple(7'h33, 5'd4, 3'd0, 5'd1, 5'd2, 7'h00);
        check("ill_err_once", 64'(err_illegal), 64'(0));
        idle(3);
        check("ill_count", 64'(seen_q.size()), 64'(2));
        if (seen_q.size() >= 2) begin
            check("ill_addr0", 64'(seen_q[0].addr), 64'h0);
            check("ill_addr1", 64'(seen_q[1].addr), 64'h1);
        end

        // Fill with out_ready low: fifth tuple is held, head stays put
        do_clear();
        seen_q.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            push_tuple(7'h33, 5'(k + 1), 3'd0, 5'd1, 5'd2, 7'h00);
        check("full_in_ready", 64'(in_ready), 64'(0));
        hold_i = out_instr;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 7'h33, 5'd5, 3'd0, 5'd1, 5'd2, 7'h00, 1'b0, 1'b1, f);
            check("fifth_held", 64'(f), 64'(0));
        end
        check("full_head_stable", 64'(out_instr), 64'(hold_i));
        check("full_head_value", 64'(out_instr), 64'(ref_pack(7'h33, 5'd1, 3'd0, 5'd1, 5'd2, 7'h00)));
        out_ready = 1'b1;
        push_tuple(7'h33, 5'd5, 3'd0, 5'd1, 5'd2, 7'h00);
        idle(8);
        check("full_drain_count", 64'(seen_q.size()), 64'(5));
        for (int k = 0; k < 5 && k < seen_q.size(); k++) begin
            check("full_drain_addr", 64'(seen_q[k].addr), 64'(k));
            check("full_drain_instr", 64'(seen_q[k].instr),
                  64'(ref_pack(7'h33, 5'(k + 1), 3'd0, 5'd1, 5'd2, 7'h00)));
        end

        // Address wrap modulo 2^ADDR_W
        do_clear();
        seen_q.delete();
        for (int k = 0; k < 258; k++)
            push_tuple(7'h33, 5'(k), 3'(k), 5'd9, 5'd10, 7'h00);
        idle(4);
        check("wrap_count", 64'(seen_q.size()), 64'(258));
        if (seen_q.size() >= 258) begin
            check("wrap_addr255", 64'(seen_q[255].addr), 64'(255));
            check("wrap_addr256", 64'(seen_q[256].addr), 64'(0));
            check("wrap_addr257", 64'(seen_q[257].addr), 64'(1));
        end

        // clear with three words buffered and a tuple presented
        do_clear();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            push_tuple(7'h33, 5'(k + 1), 3'd0, 5'd1, 5'd2, 7'h00);
        push_tuple(7'h13, 5'd1, 3'd0, 5'd1, 5'd2, 7'h00);
        step(1'b1, 7'h33, 5'd9, 3'd0, 5'd1, 5'd2, 7'h00, 1'b1, 1'b1, f);
        check("clr_out_valid", 64'(out_valid), 64'(0));
        check("clr_out_instr", 64'(out_instr), 64'(0));
        check("clr_cnt", 64'(illegal_cnt), 64'(0));
        out_ready = 1'b1;
        seen_q.delete();
        push_tuple(7'h33, 5'd8, 3'd0, 5'd1, 5'd2, 7'h00);
        idle(3);
        check("clr_seen", 64'(seen_q.size()), 64'(1));
        if (seen_q.size() >= 1) check("clr_addr", 64'(seen_q[0].addr), 64'(BASE));

        // Reset mid-stream
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            push_tuple(7'h33, 5'(k + 1), 3'd0, 5'd1, 5'd2, 7'h00);
        push_tuple(7'h33, 5'd1, 3'd2, 5'd1, 5'd2, 7'h20);
        step(1'b1, 7'h33, 5'd9, 3'd0, 5'd1, 5'd2, 7'h00, 1'b0, 1'b0, f);
        check("mrst_out_valid", 64'(out_valid), 64'(0));
        check("mrst_in_ready", 64'(in_ready), 64'(0));
        check("mrst_out_instr", 64'(out_instr), 64'(0));
        check("mrst_out_addr", 64'(out_addr), 64'(0));
        check("mrst_err", 64'(err_illegal), 64'(0));
        check("mrst_cnt", 64'(illegal_cnt), 64'(0));
        out_ready = 1'b1;
        seen_q.delete();
        push_tuple(7'h33, 5'd8, 3'd0, 5'd1, 5'd2, 7'h00);
        idle(3);
        check("mrst_seen", 64'(seen_q.size()), 64'(1));
        if (seen_q.size() >= 1) check("mrst_addr", 64'(seen_q[0].addr), 64'(BASE));

        // Saturating drop counter
        do_clear();
        for (int k = 0; k < 260; k++)
            push_tuple(7'h13, 5'(k), 3'(k), 5'd1, 5'd2, 7'(k));
        check("sat_cnt", 64'(illegal_cnt), 64'(255));
        do_clear();

        // Randomized traffic with back-pressure, occasional clear and reset
        for (int k = 0; k < 1200; k++) begin
            logic [6:0] op;
            logic [6:0] f7;
            int         r;
            out_ready = ($urandom % 10) < 7;
            op = (($urandom % 5) == 0) ? 7'($urandom) : 7'h33;
            r  = int'($urandom % 4);
            f7 = (r == 0) ? 7'h00 : ((r == 3) ? 7'($urandom) : 7'h20);
            step(($urandom % 10) < 7, op, 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), f7,
                 ($urandom % 100) == 0, ($urandom % 400) != 0, f);
        end

        out_ready = 1'b1;
        idle(10);
        check("final_out_valid", 64'(out_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rtype_instr_encoder.md
Name: rtype_instr_encoder

Overview:
Inverse of the instruction field decoder. Accepts R-type field tuples (opcode, rd, funct3, rs1, rs2, funct7) over a valid/ready handshake and checks them against the supported ALU op set. Legal tuples are packed into 32-bit RV32 instruction words, tagged with a sequential instruction-memory address, and buffered in a small FIFO. The output streams words and addresses to the instruction-memory loader or testbench. Illegal tuples are dropped and counted.

Parameters:
ADDR_W, 8, width of instruction address counter (word address)
DEPTH, 4, output FIFO depth (power of two, >=2)
BASE_ADDR, 0, address loaded on reset and on clear

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
clear  in  1  sync pulse: flush FIFO, reload address counter, zero illegal_cnt
in_valid  in  1  field tuple valid
in_ready  out  1  encoder can accept tuple
opcode  in  7  instruction[6:0]
rd  in  5  instruction[11:7]
funct3  in  3  instruction[14:12]
rs1  in  5  instruction[19:15]
rs2  in  5  instruction[24:20]
funct7  in  7  instruction[31:25]
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_instr  out  32  packed instruction at FIFO head
out_addr  out  ADDR_W  word address of out_instr
err_illegal  out  1  one-cycle pulse, illegal tuple dropped
illegal_cnt  out  8  saturating count of dropped tuples

Behaviour:
- Reset (rst_n=0 at clk edge): FIFO empty, out_valid=0, out_instr=0, out_addr=0, addr counter=BASE_ADDR, err_illegal=0, illegal_cnt=0, in_ready=0 during reset cycle, then 1.
- Handshake: transfer on in_valid&&in_ready; out transfer on out_valid&&out_ready. in_ready = !full (registered count, no combinational path from out_ready).
- Legality: opcode==7'b0110011 AND (funct7==7'h00 OR (funct7==7'h20 AND funct3 in {000,101})). Anything else is illegal.
- Legal accept: push {funct7,rs2,rs1,funct3,rd,opcode} with current addr; addr counter +1, wraps modulo 2^ADDR_W.
- Illegal accept: no push, addr unchanged. err_illegal=1 the following cycle only. illegal_cnt+1, saturating at 255. Illegal tuples are still accepted (consume in_ready handshake).
- Latency: tuple accepted at edge N appears at out_* after edge N (visible cycle N+1). No combinational fall-through when empty.
- out_instr/out_addr are held stable while out_valid&&!out_ready. They hold their last value (or 0 after reset/clear) when empty.
- Simultaneous push+pop, not full and not empty: occupancy unchanged, order preserved.
- Full: in_ready=0; a pop in that cycle does not enable a same-cycle push.
- clear: takes priority over push/pop in that cycle. FIFO empties, addr=BASE_ADDR, illegal_cnt=0, and any tuple presented that cycle is discarded.
- Reset mid-stream: same as clear plus all outputs return to reset values. No partial words are emitted.
- Unknown/X on fields while in_valid=0 must not affect state.

Decomposition:
- Package riscv_isa_pkg: OPC_RTYPE=7'b0110011, F7_BASE=7'h00, F7_ALT=7'h20, F3_ADD_SUB=3'b000, F3_SRL_SRA=3'b101, packed struct rtype_fields_t {funct7,rs2,rs1,funct3,rd,opcode} (32 bits, so the cast gives the instruction word).
- Sub-module: sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count, registered read data, sync active-low reset plus flush). Encoder instantiates it with WIDTH=32+ADDR_W.

Test Plan:
- add x3,x1,x2 (f7=00,rs2=2,rs1=1,f3=0,rd=3,op=33) after reset -> one cycle later out_instr=0x002081B3, out_addr=0x00.
- Back-to-back sub x5,x6,x7 then sra x1,x2,x3 with out_ready=1 -> 0x407302B3 @addr 0, 0x403150B3 @addr 1. Order kept, no bubbles.
- f7=0x20,f3=111 (illegal) between two adds -> err_illegal pulses once, illegal_cnt=1, the adds get consecutive addrs 0,1.
- out_ready=0, push 5 legal tuples (DEPTH=4) -> in_ready drops after 4th accept, 5th held. out_* stable. After releasing out_ready, all 5 drain in order with addrs 0..4.
- ADDR_W=2, push 5 legal tuples draining freely -> out_addr sequence 0,1,2,3,0.
- FIFO holding 3 words, assert clear with in_valid=1 -> next cycle out_valid=0, next legal tuple gets addr BASE_ADDR, illegal_cnt=0. Repeat with rst_n=0 mid-stream: same result.
